// File: rtl/gt_drp_arbiter_pkg.sv
// rtl/gt_drp_arbiter_pkg.sv - shared types and constants for the GT_COMMON DRP arbiter
// Contents: drp_arb_state_t FSM encoding, default DRP address/data widths.
package gt_drp_arbiter_pkg;

  localparam int DRP_AW = 8;
  localparam int DRP_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } drp_arb_state_t;

endpackage

// File: rtl/gt_drp_arbiter_rr_pick.sv
// rtl/gt_drp_arbiter_rr_pick.sv - combinational round-robin picker
// Ports:
//   req   in  N  pending requests
//   last  in  W  most recent grantee; search starts at last+1
//   any   out 1  at least one request pending
//   grant out W  first pending index after last, modulo N
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] grant
);

  int idx;

  // Walk offsets from farthest to nearest so the candidate closest to
  // last+1 is written last and therefore wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        any   = 1'b1;
        grant = W'(idx);
      end
    end
  end

endmodule

// File: rtl/gt_drp_arbiter.sv
// rtl/gt_drp_arbiter.sv - round-robin arbiter sharing one GT_COMMON DRP port
// Optional macro GT_DRP_ARBITER_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with resp_err.
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   req_valid/req_ready/req_we    per-requester request handshake and direction
//   req_addr/req_di               packed per-requester address and write data
//   resp_valid/resp_data/resp_err per-requester completion pulse, shared data/error
//   drp_en/drp_we/drp_addr/drp_di DRP master side toward gt_common_wrapper
//   drp_do/drp_rdy                DRP read data and completion
//   busy/owner                    transaction in progress, current/last grantee
module gt_drp_arbiter
  import gt_drp_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int AW      = DRP_AW,
  parameter int DW      = DRP_DW,
  parameter int TIMEOUT = 255
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*AW-1:0]        req_addr,
  input  logic [N_REQ*DW-1:0]        req_di,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [DW-1:0]              resp_data,
  output logic                       resp_err,
  output logic                       drp_en,
  output logic                       drp_we,
  output logic [AW-1:0]              drp_addr,
  output logic [DW-1:0]              drp_di,
  input  logic [DW-1:0]              drp_do,
  input  logic                       drp_rdy,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner
);

  localparam int OW = $clog2(N_REQ);

  drp_arb_state_t state, state_nxt;
  logic [OW-1:0]  last;
  logic           pick_any;
  logic [OW-1:0]  pick_grant;
  logic           timed_out;

  rr_pick #(.N(N_REQ), .W(OW)) u_pick (
    .req   (req_valid),
    .last  (last),
    .any   (pick_any),
    .grant (pick_grant)
  );

`ifdef GT_DRP_ARBITER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;

  // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT.
  assign timed_out = (state == WAIT) && !drp_rdy && (wait_cnt == 16'(TIMEOUT - 1));
  assign resp_err  = err_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !drp_rdy) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timed_out      = 1'b0;
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      last      <= OW'(N_REQ - 1);
      owner     <= '0;
      drp_we    <= 1'b0;
      drp_addr  <= '0;
      drp_di    <= '0;
      resp_data <= '0;
`ifdef GT_DRP_ARBITER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // The request is committed at grant time; the DRP-side outputs are
      // the latches themselves, so they stay stable until the next grant.
      if (state == IDLE && pick_any) begin
        owner    <= pick_grant;
        last     <= pick_grant;
        drp_we   <= req_we[pick_grant];
        drp_addr <= req_addr[int'(pick_grant)*AW +: AW];
        drp_di   <= req_di[int'(pick_grant)*DW +: DW];
      end
      if (state == WAIT && drp_rdy) begin
        resp_data <= drp_do;
`ifdef GT_DRP_ARBITER_TIMEOUT_EN
        err_q     <= 1'b0;
`endif
      end else if (timed_out) begin
        resp_data <= '0;
`ifdef GT_DRP_ARBITER_TIMEOUT_EN
        err_q     <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    drp_en     = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (pick_any) state_nxt = ISSUE;
      ISSUE: begin
        drp_en           = 1'b1;
        req_ready[owner] = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT:  if (drp_rdy || timed_out) state_nxt = RESP;
      RESP: begin
        resp_valid[owner] = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gt_drp_arbiter.sv
// tb/tb_gt_drp_arbiter.sv - directed self-checking bench for gt_drp_arbiter
module tb_gt_drp_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_di = '0;
  logic [1:0]  resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        drp_en;
  logic        drp_we;
  logic [7:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_rdy = 1'b0;
  logic        busy;
  logic [0:0]  owner;

  int errors = 0;
  int checks = 0;
  int en_pulses = 0;
  int resp_cnt0 = 0;
  int resp_cnt1 = 0;
  bit outstanding = 1'b0;
  int snap_en;
  int snap_r0;
  int snap_r1;
  int exp_owner;
  int wait_cycles;

  gt_drp_arbiter #(.N_REQ(2), .AW(8), .DW(16), .TIMEOUT(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_di     (req_di),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .drp_en     (drp_en),
    .drp_we     (drp_we),
    .drp_addr   (drp_addr),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_rdy    (drp_rdy),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Called in the ISSUE cycle; raises drp_rdy after lat further cycles and
  // returns in the RESP cycle.
  task automatic serve(input int lat, input logic [15:0] dout);
    for (int i = 0; i < lat; i++) tick();
    drp_rdy = 1'b1;
    drp_do  = dout;
    tick();
    drp_rdy = 1'b0;
    drp_do  = 16'h0000;
  endtask

  // Protocol monitor: one drp_en per completed transaction.
  always @(negedge aclk) begin
    if (!aresetn) begin
      outstanding = 1'b0;
    end else begin
      if (drp_en) begin
        checks++;
        assert (!outstanding) else begin
          errors++;
          $error("FAIL en_overlap: observed=drp_en while outstanding expected=no overlap");
        end
        outstanding = 1'b1;
        en_pulses++;
      end
      if (resp_valid != 2'b00) outstanding = 1'b0;
      if (resp_valid[0]) resp_cnt0++;
      if (resp_valid[1]) resp_cnt1++;
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    aresetn = 1'b1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drp_en", 32'(drp_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_drp_addr", 32'(drp_addr), 32'h0);
    tick();

    // Single read, requester 0
    snap_en = en_pulses; snap_r0 = resp_cnt0;
    req_valid = 2'b01; req_we = 2'b00; req_addr = 16'h003C;
    tick();
    chk("rd_drp_en", 32'(drp_en), 32'h1);
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_addr", 32'(drp_addr), 32'h3C);
    chk("rd_we", 32'(drp_we), 32'h0);
    chk("rd_owner", 32'(owner), 32'h0);
    req_valid = 2'b00;
    serve(2, 16'h1234);
    chk("rd_resp_valid", 32'(resp_valid), 32'h1);
    chk("rd_resp_data", 32'(resp_data), 32'h1234);
    chk("rd_resp_err", 32'(resp_err), 32'h0);
    tick();
    chk("rd_idle_busy", 32'(busy), 32'h0);
    chk("rd_resp_done", 32'(resp_valid), 32'h0);
    chk("rd_data_hold", 32'(resp_data), 32'h1234);
    chk("rd_en_count", 32'(en_pulses - snap_en), 32'h1);
    chk("rd_resp_count", 32'(resp_cnt0 - snap_r0), 32'h1);

    // Single write, requester 1; drp_rdy during ISSUE must be ignored
    snap_en = en_pulses; snap_r1 = resp_cnt1;
    req_valid = 2'b10; req_we = 2'b10; req_addr = 16'h0A00; req_di = 32'hBEEF_0000;
    tick();
    chk("wr_drp_en", 32'(drp_en), 32'h1);
    chk("wr_ready", 32'(req_ready), 32'h2);
    chk("wr_we", 32'(drp_we), 32'h1);
    chk("wr_addr", 32'(drp_addr), 32'h0A);
    chk("wr_di", 32'(drp_di), 32'hBEEF);
    req_valid = 2'b00;
    drp_rdy = 1'b1; drp_do = 16'h5555;
    tick();
    drp_rdy = 1'b0;
    chk("wr_issue_rdy_ignored", 32'(resp_valid), 32'h0);
    chk("wr_wait_busy", 32'(busy), 32'h1);
    tick();
    chk("wr_still_wait", 32'(resp_valid), 32'h0);
    drp_rdy = 1'b1; drp_do = 16'h7777;
    tick();
    drp_rdy = 1'b0;
    chk("wr_resp_valid", 32'(resp_valid), 32'h2);
    chk("wr_resp_data", 32'(resp_data), 32'h7777);
    tick();
    chk("wr_en_count", 32'(en_pulses - snap_en), 32'h1);
    chk("wr_resp_count", 32'(resp_cnt1 - snap_r1), 32'h1);
    chk("wr_hold_we", 32'(drp_we), 32'h1);

    // Simultaneous requests right after reset
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_addr = 16'h2211;
    tick();
    chk("sim_owner0", 32'(owner), 32'h0);
    chk("sim_ready0", 32'(req_ready), 32'h1);
    chk("sim_addr0", 32'(drp_addr), 32'h11);
    req_valid = 2'b10;
    serve(1, 16'hAAAA);
    chk("sim_resp0", 32'(resp_valid), 32'h1);
    chk("sim_data0", 32'(resp_data), 32'hAAAA);
    tick();
    chk("sim_gap_idle", 32'(busy), 32'h0);
    tick();
    chk("sim_owner1", 32'(owner), 32'h1);
    chk("sim_ready1", 32'(req_ready), 32'h2);
    chk("sim_addr1", 32'(drp_addr), 32'h22);
    req_valid = 2'b00;
    serve(1, 16'hBBBB);
    chk("sim_resp1", 32'(resp_valid), 32'h2);
    chk("sim_data1", 32'(resp_data), 32'hBBBB);
    tick();

    // Fairness: both held for 10 transactions, grants alternate from 0
    req_valid = 2'b11;
    exp_owner = 0;
    for (int t = 0; t < 10; t++) begin
      wait_cycles = 0;
      while (!drp_en && wait_cycles < 6) begin
        tick();
        wait_cycles++;
      end
      chk("fair_en_seen", 32'(drp_en), 32'h1);
      chk("fair_owner", 32'(owner), 32'(exp_owner));
      chk("fair_ready", 32'(req_ready), 32'(1 << exp_owner));
      serve(1 + (t % 3), 16'(16'h0100 + t));
      chk("fair_resp", 32'(resp_valid), 32'(1 << exp_owner));
      chk("fair_data", 32'(resp_data), 32'(16'h0100 + t));
      exp_owner ^= 1;
    end
    req_valid = 2'b00;
    tick(); tick();
    chk("fair_idle", 32'(busy), 32'h0);

    // Reset mid-WAIT after a requester-0 grant; pointer must return to 1
    req_valid = 2'b01; req_we = 2'b00; req_addr = 16'h0044;
    tick();
    chk("rw_owner0", 32'(owner), 32'h0);
    req_valid = 2'b00;
    tick();
    chk("rw_in_wait", 32'(busy), 32'h1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_drp_en", 32'(drp_en), 32'h0);
    chk("rw_resp_valid", 32'(resp_valid), 32'h0);
    chk("rw_owner", 32'(owner), 32'h0);
    chk("rw_resp_data", 32'(resp_data), 32'h0);
    req_valid = 2'b11;
    tick();
    chk("rw_grant0", 32'(owner), 32'h0);
    chk("rw_ready0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    serve(1, 16'h0F0F);
    chk("rw_resp0", 32'(resp_valid), 32'h1);
    tick();

`ifdef GT_DRP_ARBITER_TIMEOUT_EN
    // Timeout: no drp_rdy, abort after 16 WAIT cycles, late rdy ignored
    req_valid = 2'b01;
    tick();
    chk("to_issue", 32'(drp_en), 32'h1);
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", 32'(resp_valid), 32'h0);
    chk("to_busy", 32'(busy), 32'h1);
    tick();
    chk("to_resp", 32'(resp_valid), 32'h1);
    chk("to_err", 32'(resp_err), 32'h1);
    chk("to_data", 32'(resp_data), 32'h0);
    tick(); tick(); tick();
    drp_rdy = 1'b1; drp_do = 16'hDEAD;
    tick();
    drp_rdy = 1'b0;
    chk("to_late_resp", 32'(resp_valid), 32'h0);
    chk("to_late_busy", 32'(busy), 32'h0);
    chk("to_err_hold", 32'(resp_err), 32'h1);
    chk("to_data_hold", 32'(resp_data), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gt_drp_arbiter.md
Name: gt_drp_arbiter

Overview:
- Shares the single GT_COMMON DRP port between N_REQ requesters, e.g. the PCIe core's QPLL0 DRP master and a QPLL1/SFP reconfiguration master driven from MMR.
- Round-robin arbitration; exactly one DRP transaction is in flight at a time.
- Per-requester valid/ready request channel and one-cycle response pulse.
- Sits between the requesters and gt_common_wrapper in the PS_clk domain.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- AW, 8, DRP address width.
- DW, 16, DRP data width.
- TIMEOUT, 255, cycles waited for drp_rdy before abort (used only with the optional feature).

Ports:
- aclk  in  1  DRP/system clock (PS_clk).
- aresetn  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  request pending, per requester.
- req_ready  out  N_REQ  request accepted; one-cycle pulse.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_di  in  N_REQ*DW  packed write data.
- resp_valid  out  N_REQ  one-cycle completion pulse to the owner.
- resp_data  out  DW  read data; shared, valid with resp_valid.
- resp_err  out  1  timeout flag; valid with resp_valid.
- drp_en  out  1  DRP enable; one-cycle pulse.
- drp_we  out  1  DRP write enable.
- drp_addr  out  AW  DRP address.
- drp_di  out  DW  DRP write data.
- drp_do  in  DW  DRP read data.
- drp_rdy  in  1  DRP completion.
- busy  out  1  transaction in progress (state != IDLE).
- owner  out  $clog2(N_REQ)  index of the current or most recent grantee.

Behaviour:
- Reset (aresetn = 0 at a posedge aclk):
  - State goes to IDLE.
  - All outputs return to 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority first.
  - A reset mid-transaction abandons it with no resp_valid; the bench must reset the GT side too.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning last+1, last+2, … modulo N_REQ.
  - Latch that requester's we/addr/di and set owner = g, last = g. Next state ISSUE.
  - The request is committed here; dropping req_valid later does not cancel it.
- ISSUE (exactly 1 cycle):
  - drp_en = 1 and req_ready[g] = 1.
  - drp_we/drp_addr/drp_di driven from the latches; they hold their values until the next ISSUE.
  - Next state WAIT.
- WAIT:
  - On drp_rdy = 1, capture drp_do into resp_data (writes capture it too, value don't-care), set resp_err = 0. Next state RESP.
  - drp_rdy is ignored in every other state, including ISSUE.
- RESP (exactly 1 cycle):
  - resp_valid[g] = 1 and busy = 1.
  - resp_data/resp_err hold until the next capture.
  - Next state IDLE.
- Latency:
  - req_valid seen in IDLE at cycle 0 → drp_en and req_ready at cycle 1.
  - drp_rdy at cycle k ≥ 2 → resp_valid at cycle k+1.
  - Minimum IDLE→IDLE turnaround is 4 cycles; back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests: only one grant per arbitration. Losers hold req_valid and are served in round-robin order, so no requester waits more than N_REQ-1 transactions.
- A requester that holds req_valid after req_ready is treated as issuing a new request.

Optional Feature:
- Macro: GT_DRP_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering WAIT and increments each WAIT cycle without drp_rdy.
  - When the count reaches TIMEOUT, go to RESP with resp_err = 1 and resp_data = 0.
  - A late drp_rdy after the abort is ignored (it arrives outside WAIT).
- Undefined: WAIT lasts indefinitely, resp_err is tied to 0, and the TIMEOUT parameter is unused.

Decomposition:
- Package gt_drp_arbiter_pkg:
  - state enum drp_arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - DRP_AW = 8, DRP_DW = 16 constants.
- Sub-module rr_pick (parameter N):
  - Inputs: req[N], last index.
  - Outputs: any, grant index.
  - Purely combinational rotate/priority-encode/rotate-back; the pointer register stays in the parent.

Test Plan:
- Single read: req0 read addr 0x3C; model returns drp_do = 0x1234 two cycles after drp_en → drp_addr = 0x3C and drp_we = 0 during drp_en; resp_valid[0] pulses once with resp_data = 0x1234, resp_err = 0.
- Single write: req1 write addr 0x0A, di 0xBEEF → exactly one drp_en with drp_we = 1 and drp_di = 0xBEEF; req_ready[1] pulses with drp_en; resp_valid[1] pulses one cycle after drp_rdy.
- Simultaneous requests from reset: req0 and req1 both valid at cycle 0 → req0 is granted first (owner = 0); req1 is granted at the next IDLE; resp_valid order is [0] then [1].
- Fairness: both requesters held valid for 10 transactions → grants strictly alternate 0,1,0,1…; never two drp_en pulses without an intervening drp_rdy.
- Timeout (macro defined, TIMEOUT = 16): drp_rdy never asserted → resp_valid with resp_err = 1 and resp_data = 0 exactly 16 WAIT cycles after entering WAIT; a drp_rdy injected 3 cycles later is ignored.
- Reset mid-WAIT: aresetn low for 1 cycle while in WAIT → next cycle busy = 0, drp_en = 0, resp_valid = 0, owner = 0; the following simultaneous request grants req0.
